// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall generation for the EX-stage operand muxes.
// Optional macro FWD_WB_BYPASS_EN: when defined, a producer found only in WB selects mux input 11.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [1:0]            fwd_a_code,
  output logic [1:0]            fwd_b_code,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  load;
    logic [REG_ADDR_W-1:0] dest;
  } entry_t;

  localparam logic [1:0] CODE_RF  = 2'b00;
  localparam logic [1:0] CODE_EX  = 2'b01;
  localparam logic [1:0] CODE_MEM = 2'b10;
`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] CODE_WB  = 2'b11;
`else
  // Register file is write-through, so a WB-only producer reads correctly from the RF.
  localparam logic [1:0] CODE_WB  = 2'b00;
`endif

  entry_t ex_q, mem_q, wb_q;
  entry_t ex_d;
  logic   load_id;
  logic   hazard_a, hazard_b;
  logic [1:0] code_a_d, code_b_d;

  function automatic logic match(input logic [REG_ADDR_W-1:0] s, input entry_t e);
    return e.valid & e.we & (e.dest == s) & (s != '0);
  endfunction

  // Youngest producer wins; a matching load in EX is handled by the stall instead.
  function automatic logic [1:0] next_code(input logic [REG_ADDR_W-1:0] s, input logic used,
                                           input entry_t ex, input entry_t mem, input entry_t wb);
    logic [1:0] c;
    c = CODE_RF;
    if (used) begin
      if (match(s, ex) && !ex.load) c = CODE_EX;
      else if (match(s, mem))       c = CODE_MEM;
      else if (match(s, wb))        c = CODE_WB;
    end
    return c;
  endfunction

  always_comb begin
    hazard_a = id_use_rs & match(id_rs, ex_q) & ex_q.load;
    hazard_b = id_use_rt & match(id_rt, ex_q) & ex_q.load;
    stall    = id_valid & ~flush & (hazard_a | hazard_b);
    load_id  = id_valid & ~stall & ~flush;

    ex_d       = '0;
    ex_d.valid = load_id;
    ex_d.we    = id_reg_write;
    ex_d.load  = id_is_load;
    ex_d.dest  = id_rd;

    code_a_d = CODE_RF;
    code_b_d = CODE_RF;
    if (load_id) begin
      code_a_d = next_code(id_rs, id_use_rs, ex_q, mem_q, wb_q);
      code_b_d = next_code(id_rt, id_use_rt, ex_q, mem_q, wb_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      fwd_a_code <= CODE_RF;
      fwd_b_code <= CODE_RF;
      stall_cnt  <= '0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= ex_q;
      wb_q       <= mem_q;
      fwd_a_code <= code_a_d;
      fwd_b_code <= code_b_d;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit; expected codes are hand-derived per scenario.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt;
  logic        id_reg_write, id_is_load;
  logic        flush;
  logic [1:0]  fwd_a_code, fwd_b_code;
  logic        stall;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] EXP_D3 = 2'b11;
`else
  localparam logic [1:0] EXP_D3 = 2'b00;
`endif

  fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .flush(flush),
    .fwd_a_code(fwd_a_code), .fwd_b_code(fwd_b_code),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_reg_write = we; id_is_load = ld; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    n_checks++; if (fwd_a_code !== 2'b00) begin n_fail++; $display("FAIL reset_a: got %b expected 00", fwd_a_code); end
    n_checks++; if (fwd_b_code !== 2'b00) begin n_fail++; $display("FAIL reset_b: got %b expected 00", fwd_b_code); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    nops(3);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    step();
    drive(1, 5, 1, 1, 1, 8, 1, 0, 0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b expected 0", stall); end
    step();
    n_checks++; if (fwd_a_code !== 2'b01) begin n_fail++; $display("FAIL b2b_a: got %b expected 01", fwd_a_code); end
    n_checks++; if (fwd_b_code !== 2'b00) begin n_fail++; $display("FAIL b2b_b: got %b expected 00", fwd_b_code); end
  endtask

  task automatic test_distance();
    nops(3);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0); step();
    drive(1, 7, 7, 0, 1, 12, 1, 0, 0); step();
    n_checks++; if (fwd_b_code !== 2'b10) begin n_fail++; $display("FAIL dist2_b: got %b expected 10", fwd_b_code); end
    n_checks++; if (fwd_a_code !== 2'b00) begin n_fail++; $display("FAIL dist2_unused_a: got %b expected 00", fwd_a_code); end
    nops(3);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 11, 1, 0, 0); step();
    drive(1, 0, 7, 0, 1, 12, 1, 0, 0); step();
    n_checks++; if (fwd_b_code !== EXP_D3) begin n_fail++; $display("FAIL dist3_b: got %b expected %b", fwd_b_code, EXP_D3); end
  endtask

  task automatic test_load_use();
    nops(3);
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0); step();
    drive(1, 3, 3, 1, 1, 13, 1, 0, 0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b expected 1", stall); end
    step();
    n_checks++; if (fwd_a_code !== 2'b00 || fwd_b_code !== 2'b00) begin n_fail++; $display("FAIL lu_bubble: got %b/%b expected 00/00", fwd_a_code, fwd_b_code); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle: got %b expected 0", stall); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt); end
    step();
    n_checks++; if (fwd_a_code !== 2'b10 || fwd_b_code !== 2'b10) begin n_fail++; $display("FAIL lu_codes: got %b/%b expected 10/10", fwd_a_code, fwd_b_code); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_hold: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_priority_r0();
    nops(3);
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0); step();
    drive(1, 9, 0, 1, 0, 14, 1, 0, 0); step();
    n_checks++; if (fwd_a_code !== 2'b01) begin n_fail++; $display("FAIL prio_a: got %b expected 01", fwd_a_code); end
    nops(3);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(1, 0, 0, 1, 1, 14, 1, 0, 0); step();
    n_checks++; if (fwd_a_code !== 2'b00 || fwd_b_code !== 2'b00) begin n_fail++; $display("FAIL r0_codes: got %b/%b expected 00/00", fwd_a_code, fwd_b_code); end
    nops(3);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0); step();
    drive(1, 0, 0, 1, 1, 14, 1, 0, 0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_load_stall: got %b expected 0", stall); end
  endtask

  task automatic test_flush();
    nops(3);
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0); step();
    drive(1, 4, 0, 1, 0, 12, 1, 0, 1);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", stall); end
    step();
    n_checks++; if (fwd_a_code !== 2'b00) begin n_fail++; $display("FAIL flush_bubble: got %b expected 00", fwd_a_code); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_cnt: got %0d expected 1", stall_cnt); end
    // the squashed instruction wrote r12; nothing may forward from it
    drive(1, 12, 4, 1, 1, 15, 1, 0, 0); step();
    n_checks++; if (fwd_a_code !== 2'b00) begin n_fail++; $display("FAIL flush_squashed_a: got %b expected 00", fwd_a_code); end
    n_checks++; if (fwd_b_code !== 2'b10) begin n_fail++; $display("FAIL flush_load_mem_b: got %b expected 10", fwd_b_code); end
  endtask

  task automatic test_reset_midstream();
    nops(3);
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0); step();
    drive(1, 6, 0, 1, 0, 2, 1, 1, 0); step();
    n_checks++; if (fwd_a_code !== 2'b01) begin n_fail++; $display("FAIL mid_pre_a: got %b expected 01", fwd_a_code); end
    drive(1, 2, 0, 1, 0, 16, 1, 0, 0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall: got %b expected 1", stall); end
    rst = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall: got %b expected 0", stall); end
    n_checks++; if (fwd_a_code !== 2'b00 || fwd_b_code !== 2'b00) begin n_fail++; $display("FAIL mid_codes: got %b/%b expected 00/00", fwd_a_code, fwd_b_code); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 0", stall_cnt); end
    #2;
    rst = 1'b0;
    step();
    n_checks++; if (stall_cnt !== 16'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL post_reset: got cnt %0d stall %b expected 0/0", stall_cnt, stall); end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_priority_r0();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
